// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, the default memory map and the default-slave state type
// for the decode/mux interconnect.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Cortex-M0 map: RAMCODE, RAMDATA, two 16-byte peripheral windows
  localparam int               DEF_NUM_PORTS = 4;
  localparam logic [4*32-1:0]  DEF_BASE_ADDR = {32'h4000_0010, 32'h4000_0000,
                                                32'h2000_0000, 32'h0000_0000};
  localparam logic [4*32-1:0]  DEF_ADDR_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                32'hFFFF_0000, 32'hFFFF_0000};

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  function automatic logic addr_match(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave answering unmapped active transfers with a two-cycle ERROR response.
// Optional error log (err_addr/err_cnt/err_irq) built when AHB_DECODE_ERRLOG_EN is defined.
module ahblite_default_slave
  import ahb_lite_pkg::*;
`ifdef AHB_DECODE_ERRLOG_EN
#(
  parameter int ERRCNT_W = 16
)
`endif
(
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                hready,
  input  logic [1:0]          htrans,
  input  logic                addr_hit,
  output logic                ds_hready,
  output logic                ds_hresp
`ifdef AHB_DECODE_ERRLOG_EN
  ,
  input  logic [31:0]         haddr,
  input  logic                err_clr,
  output logic [31:0]         err_addr,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                err_irq
`endif
);

  ds_state_e state_q, state_d;
  logic      err_start;
  logic      active_xfer;

  assign active_xfer = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

  // ERR2 completes the error and may immediately accept the next bad address
  always_comb begin
    state_d   = state_q;
    ds_hready = 1'b1;
    ds_hresp  = HRESP_OKAY;
    err_start = 1'b0;
    case (state_q)
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = HRESP_ERROR;
        state_d   = DS_ERR2;
      end
      default: begin
        if (state_q == DS_ERR2) ds_hresp = HRESP_ERROR;
        state_d = DS_IDLE;
        if (hready && active_xfer && !addr_hit) begin
          err_start = 1'b1;
          state_d   = DS_ERR1;
        end
      end
    endcase
  end

`ifdef AHB_DECODE_ERRLOG_EN
  // Clear beats a coincident increment; the captured address survives a clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_addr <= '0;
      err_cnt  <= '0;
      err_irq  <= 1'b0;
    end else begin
      if (err_start) err_addr <= haddr;
      if (err_clr) begin
        err_cnt <= '0;
        err_irq <= 1'b0;
      end else if (err_start) begin
        if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
        err_irq <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahblite_decode_mux.sv
// AHB-Lite address decoder, data-phase owner register and response mux with built-in default slave.
// Define AHB_DECODE_ERRLOG_EN to add the err_addr/err_cnt/err_irq/err_clr error log.
module ahblite_decode_mux
  import ahb_lite_pkg::*;
#(
  parameter int                      NUM_PORTS = DEF_NUM_PORTS,
  parameter logic [NUM_PORTS-1:0]    PORT_EN   = '1,
  parameter logic [NUM_PORTS*32-1:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [NUM_PORTS*32-1:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int                      ERRCNT_W  = 16
)
(
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic                    HREADY,
  output logic                    HRESP,
  output logic [31:0]             HRDATA,
  output logic [NUM_PORTS-1:0]    HSEL_S,
  input  logic [NUM_PORTS-1:0]    HREADYOUT_S,
  input  logic [NUM_PORTS-1:0]    HRESP_S,
  input  logic [NUM_PORTS*32-1:0] HRDATA_S
`ifdef AHB_DECODE_ERRLOG_EN
  ,
  output logic [31:0]             err_addr,
  output logic [ERRCNT_W-1:0]     err_cnt,
  output logic                    err_irq,
  input  logic                    err_clr
`endif
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || ERRCNT_W < 1) begin : g_bad_cfg
    $error("ahblite_decode_mux: unsupported NUM_PORTS/ERRCNT_W");
  end

  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic             dsel_valid;
  logic [IDX_W-1:0] dsel_idx;
  logic             ds_hready;
  logic             ds_hresp;

  // Scan downwards so the lowest-numbered overlapping port is the one kept
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (PORT_EN[i] && addr_match(HADDR, BASE_ADDR[32*i +: 32], ADDR_MASK[32*i +: 32])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    HSEL_S = '0;
    if (hit_any) HSEL_S = NUM_PORTS'(1) << hit_idx;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_valid <= 1'b0;
      dsel_idx   <= '0;
    end else if (HREADY) begin
      dsel_valid <= hit_any;
      dsel_idx   <= hit_idx;
    end
  end

  always_comb begin
    HREADY = ds_hready;
    HRESP  = ds_hresp;
    HRDATA = '0;
    if (dsel_valid) begin
      HREADY = HREADYOUT_S[dsel_idx];
      HRESP  = HRESP_S[dsel_idx];
      HRDATA = HRDATA_S[32*dsel_idx +: 32];
    end
  end

  ahblite_default_slave
`ifdef AHB_DECODE_ERRLOG_EN
    #(.ERRCNT_W(ERRCNT_W))
`endif
  u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .hready    (HREADY),
    .htrans    (HTRANS),
    .addr_hit  (hit_any),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp)
`ifdef AHB_DECODE_ERRLOG_EN
    ,
    .haddr     (HADDR),
    .err_clr   (err_clr),
    .err_addr  (err_addr),
    .err_cnt   (err_cnt),
    .err_irq   (err_irq)
`endif
  );

endmodule

// File: tb/tb_ahblite_decode_mux.sv
// Randomized scoreboard bench for ahblite_decode_mux against an address-range memory map model.
// Error-log checks are compiled in when AHB_DECODE_ERRLOG_EN is defined.
module tb_ahblite_decode_mux;
  import ahb_lite_pkg::*;

  localparam int NP      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [31:0]       HADDR;
  logic [1:0]        HTRANS;
  logic              HREADY;
  logic              HRESP;
  logic [31:0]       HRDATA;
  logic [NP-1:0]     HSEL_S;
  logic [NP-1:0]     HREADYOUT_S;
  logic [NP-1:0]     HRESP_S;
  logic [NP*32-1:0]  HRDATA_S;
`ifdef AHB_DECODE_ERRLOG_EN
  logic [31:0]       err_addr;
  logic [CW-1:0]     err_cnt;
  logic              err_irq;
  logic              err_clr;
`endif

  ahblite_decode_mux #(
    .NUM_PORTS (NP),
    .PORT_EN   (4'b1111),
    .BASE_ADDR ({32'h4000_0010, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .ADDR_MASK ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000}),
    .ERRCNT_W  (CW)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .HSEL_S      (HSEL_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S)
`ifdef AHB_DECODE_ERRLOG_EN
    ,
    .err_addr    (err_addr),
    .err_cnt     (err_cnt),
    .err_irq     (err_irq),
    .err_clr     (err_clr)
`endif
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        hready;
    logic        hresp;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    int          waits;
    logic [31:0] data;
  } xfer_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  bit    mon_en = 1'b0;
  bit    final_mode = 1'b0;
  int    n_xfer = 0;
  xfer_t a_x;
  xfer_t d_x;
  int    d_port = -1;
  bit    d_valid = 1'b0;
  int    wait_left = 0;
  int    m_cnt = 0;
  bit    m_irq = 1'b0;
  logic [31:0] m_addr = '0;

  // Memory map as plain address ranges, first listed region wins
  function automatic int ref_port(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h2000_0000 && a <= 32'h2000_FFFF) return 1;
    if (a >= 32'h4000_0000 && a <= 32'h4000_000F) return 2;
    if (a >= 32'h4000_0010 && a <= 32'h4000_001F) return 3;
    return -1;
  endfunction

  function automatic logic [NP-1:0] ref_hsel(input logic [31:0] a);
    int p;
    p = ref_port(a);
    if (p < 0) return '0;
    return NP'(1) << p;
  endfunction

  function automatic xfer_t new_xfer();
    xfer_t x;
    x.data  = $urandom;
    x.waits = 0;
    if (final_mode) begin
      x.addr  = 32'h5000_0000;
      x.trans = HTRANS_NONSEQ;
      return x;
    end
    x.trans = HTRANS_NONSEQ;
    case (n_xfer)
      0: x.addr = 32'h0000_1234;
      1: begin x.addr = 32'h2000_0010; x.waits = 1; end
      2: begin x.addr = 32'h4000_0004; x.waits = 3; x.data = 32'hA5A5_0001; end
      3: x.addr = 32'h4000_0018;
      4: x.addr = 32'h5000_0000;
      5: begin x.addr = 32'h5000_0000; x.trans = HTRANS_IDLE; end
      6: x.addr = 32'h6000_0000;
      7: begin x.addr = 32'h7000_0004; x.trans = HTRANS_SEQ; end
      default: begin
        x.trans = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
          0: x.addr = {16'h0000, 16'($urandom)};
          1: x.addr = {16'h2000, 16'($urandom)};
          2: x.addr = 32'h4000_0000 | 32'($urandom_range(0, 15));
          3: x.addr = 32'h4000_0010 | 32'($urandom_range(0, 15));
          4: case ($urandom_range(0, 3))
               0: x.addr = 32'h0001_0000;
               1: x.addr = 32'h1FFF_FFFF;
               2: x.addr = 32'h2001_0000;
               default: x.addr = 32'h4000_0020;
             endcase
          default: x.addr = 32'h8000_0000 | 32'($urandom);
        endcase
        if (x.trans[1] && $urandom_range(0, 2) == 0) x.waits = $urandom_range(1, 3);
      end
    endcase
    return x;
  endfunction

  task automatic push_exp(input logic r, input logic s, input logic c, input logic [31:0] d);
    exp_t e;
    e.hready   = r;
    e.hresp    = s;
    e.chk_data = c;
    e.data     = d;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after each rising edge; accept says whether that edge completed the address phase
  task automatic applyStimulus(input bit accept);
    bit unm_act;
    unm_act = (ref_port(a_x.addr) < 0) && a_x.trans[1];
`ifdef AHB_DECODE_ERRLOG_EN
    if (accept && unm_act) m_addr = a_x.addr;
    if (err_clr) begin
      m_cnt = 0;
      m_irq = 1'b0;
    end else if (accept && unm_act) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      m_irq = 1'b1;
    end
    err_clr = (n_xfer > 150) && ($urandom_range(0, 7) == 0);
`endif
    if (accept) begin
      d_x     = a_x;
      d_valid = 1'b1;
      d_port  = ref_port(a_x.addr);
      wait_left = (d_port >= 0) ? d_x.waits : 0;
      if (d_port >= 0) begin
        for (int k = 0; k < wait_left; k++) push_exp(1'b0, HRESP_OKAY, 1'b0, '0);
        push_exp(1'b1, HRESP_OKAY, 1'b1, d_x.data);
      end else if (unm_act) begin
        push_exp(1'b0, HRESP_ERROR, 1'b1, '0);
        push_exp(1'b1, HRESP_ERROR, 1'b1, '0);
      end else begin
        push_exp(1'b1, HRESP_OKAY, 1'b1, '0);
      end
      a_x = new_xfer();
      n_xfer++;
    end else if (wait_left > 0) begin
      wait_left--;
    end
    HADDR  = a_x.addr;
    HTRANS = a_x.trans;
    for (int i = 0; i < NP; i++) begin
      HREADYOUT_S[i]        = 1'($urandom);
      HRESP_S[i]            = 1'($urandom);
      HRDATA_S[32*i +: 32]  = $urandom;
    end
    if (d_valid && d_port >= 0) begin
      HREADYOUT_S[d_port]        = (wait_left == 0);
      HRESP_S[d_port]            = HRESP_OKAY;
      HRDATA_S[32*d_port +: 32]  = (wait_left == 0) ? d_x.data : $urandom;
    end
  endtask

  // Monitor: one scoreboard entry per data-phase cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (mon_en) begin
        checkOutput("hsel", 32'(HSEL_S), 32'(ref_hsel(HADDR)));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("hready", 32'(HREADY), 32'(e.hready));
          checkOutput("hresp", 32'(HRESP), 32'(e.hresp));
          if (e.chk_data) checkOutput("hrdata", HRDATA, e.data);
        end
`ifdef AHB_DECODE_ERRLOG_EN
        checkOutput("err_cnt", 32'(err_cnt), 32'(m_cnt));
        checkOutput("err_irq", 32'(err_irq), 32'(m_irq));
        checkOutput("err_addr", err_addr, m_addr);
`endif
      end
    end
  end

  initial begin
    bit accept;
    bit stalled;
    HRESETn     = 1'b0;
    a_x.addr    = 32'h5000_0000;
    a_x.trans   = HTRANS_IDLE;
    a_x.waits   = 0;
    a_x.data    = '0;
    d_x         = a_x;
    HADDR       = a_x.addr;
    HTRANS      = a_x.trans;
    HREADYOUT_S = '0;
    HRESP_S     = '1;
    HRDATA_S    = {NP{32'hDEAD_BEEF}};
`ifdef AHB_DECODE_ERRLOG_EN
    err_clr     = 1'b0;
`endif
    repeat (2) @(negedge HCLK);
    checkOutput("reset_hready", 32'(HREADY), 32'd1);
    checkOutput("reset_hresp", 32'(HRESP), 32'd0);
    checkOutput("reset_hrdata", HRDATA, 32'd0);
    checkOutput("reset_hsel", 32'(HSEL_S), 32'd0);
`ifdef AHB_DECODE_ERRLOG_EN
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("reset_err_irq", 32'(err_irq), 32'd0);
`endif
    HRESETn = 1'b1;
    mon_en  = 1'b1;

    for (int cyc = 0; cyc < 1500; cyc++) begin
      accept = HREADY;
      @(posedge HCLK);
      #1;
      applyStimulus(accept);
      @(negedge HCLK);
    end

    // Steer to an unmapped NONSEQ, then reset asynchronously mid-error
    final_mode = 1'b1;
    stalled    = 1'b0;
    for (int g = 0; g < 50 && !stalled; g++) begin
      if (!HREADY) begin
        stalled = 1'b1;
      end else begin
        accept = HREADY;
        @(posedge HCLK);
        #1;
        applyStimulus(accept);
        @(negedge HCLK);
      end
    end
    if (!stalled) begin
      checks++;
      errors++;
      $display("[TB] FAIL stall_timeout: got no wait state expected one within 50 cycles");
    end
    #2;
    mon_en = 1'b0;
    sb.delete();
    HRESETn = 1'b0;
    #1;
    checkOutput("midreset_hready", 32'(HREADY), 32'd1);
    checkOutput("midreset_hresp", 32'(HRESP), 32'd0);
    checkOutput("midreset_hrdata", HRDATA, 32'd0);
`ifdef AHB_DECODE_ERRLOG_EN
    checkOutput("midreset_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("midreset_err_irq", 32'(err_irq), 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
